// File: rtl/if_fetch_if.sv
// Instruction-ROM handshake bundle for the fetch stage: request/address out
// of the fetch unit, ready/data back from the ROM.
interface if_fetch_if;
  logic        rom_request;
  logic [31:0] rom_address;
  logic        rom_ready;
  logic [31:0] rom_data;

  modport master (
    output rom_request,
    output rom_address,
    input  rom_ready,
    input  rom_data
  );

  modport slave (
    input  rom_request,
    input  rom_address,
    output rom_ready,
    output rom_data
  );
endinterface

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, handshakes with the instruction ROM,
// follows the stall bus and branch redirects, and injects zero-word bubbles.
// Optional macro IF_HOLD_BUFFER_EN keeps a ROM response that arrives under stall.
module if_fetch (
  input  logic              clock,
  input  logic              reset,
  input  logic [5:0]        stop_all_i,
  input  logic              branch_flag_i,
  input  logic [31:0]       branch_target_address_i,
  if_fetch_if.master        rom,
  output logic [31:0]       if_program_counter_o,
  output logic [31:0]       if_instruction_o
);

  localparam logic        STOP      = 1'b1;
  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_FETCH = 2'b01;
`ifdef IF_HOLD_BUFFER_EN
  localparam logic [1:0] ST_HOLD  = 2'b10;
`endif

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        pending_branch_q, pending_branch_d;
  logic [31:0] pending_target_q, pending_target_d;
  logic [31:0] out_pc_q, out_pc_d;
  logic [31:0] out_instr_q, out_instr_d;
`ifdef IF_HOLD_BUFFER_EN
  logic [31:0] hold_data_q, hold_data_d;
`endif

  logic        stall_s;
  logic        branch_s;
  logic        accept_s;
  logic [31:0] accept_data_s;
  logic        unused_stop_s;

  assign unused_stop_s = ^stop_all_i[5:2];

  // Stall decode, branch qualification and accept selection.
  always_comb begin
    stall_s  = (stop_all_i[0] == STOP) || (stop_all_i[1] == STOP);
    branch_s = branch_flag_i && (stop_all_i[0] != STOP);
`ifdef IF_HOLD_BUFFER_EN
    if (state_q == ST_HOLD) begin
      accept_s      = !stall_s;
      accept_data_s = hold_data_q;
    end else begin
      accept_s      = (state_q == ST_FETCH) && rom.rom_ready && !stall_s;
      accept_data_s = rom.rom_data;
    end
`else
    accept_s      = (state_q == ST_FETCH) && rom.rom_ready && !stall_s;
    accept_data_s = rom.rom_data;
`endif
  end

  // Next-state logic for the FSM, PC, redirect and IF output registers.
  always_comb begin
    state_d          = state_q;
    pc_d             = pc_q;
    pending_branch_d = pending_branch_q;
    pending_target_d = pending_target_q;
    out_pc_d         = out_pc_q;
    out_instr_d      = out_instr_q;
`ifdef IF_HOLD_BUFFER_EN
    hold_data_d      = hold_data_q;
`endif

    case (state_q)
      ST_IDLE: begin
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
`ifdef IF_HOLD_BUFFER_EN
        if (rom.rom_ready && stall_s) begin
          hold_data_d = rom.rom_data;
          state_d     = ST_HOLD;
        end else begin
          state_d = ST_FETCH;
        end
`else
        state_d = ST_FETCH;
`endif
      end
`ifdef IF_HOLD_BUFFER_EN
      ST_HOLD: begin
        if (!stall_s) begin
          state_d = ST_FETCH;
        end else begin
          state_d = ST_HOLD;
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // The in-flight fetch is the delay slot; a redirect only steers the next PC.
    if (accept_s) begin
      out_pc_d         = pc_q;
      out_instr_d      = accept_data_s;
      pending_branch_d = 1'b0;
      if (pending_branch_q) begin
        pc_d = pending_target_q;
      end else if (branch_s) begin
        pc_d = branch_target_address_i;
      end else begin
        pc_d = pc_q + 32'd4;
      end
    end else begin
      if (branch_s) begin
        pending_branch_d = 1'b1;
        pending_target_d = branch_target_address_i;
      end else begin
        pending_branch_d = pending_branch_q;
      end
      if (stop_all_i[1] == STOP) begin
        out_pc_d    = out_pc_q;
        out_instr_d = out_instr_q;
      end else begin
        out_pc_d    = ZERO_WORD;
        out_instr_d = ZERO_WORD;
      end
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q          <= ST_IDLE;
      pc_q             <= ZERO_WORD;
      pending_branch_q <= 1'b0;
      pending_target_q <= ZERO_WORD;
      out_pc_q         <= ZERO_WORD;
      out_instr_q      <= ZERO_WORD;
`ifdef IF_HOLD_BUFFER_EN
      hold_data_q      <= ZERO_WORD;
`endif
    end else begin
      state_q          <= state_d;
      pc_q             <= pc_d;
      pending_branch_q <= pending_branch_d;
      pending_target_q <= pending_target_d;
      out_pc_q         <= out_pc_d;
      out_instr_q      <= out_instr_d;
`ifdef IF_HOLD_BUFFER_EN
      hold_data_q      <= hold_data_d;
`endif
    end
  end

  assign rom.rom_request      = (state_q == ST_FETCH);
  assign rom.rom_address      = pc_q;
  assign if_program_counter_o = out_pc_q;
  assign if_instruction_o     = out_instr_q;

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: the ROM model returns address ^ 0x1000 and
// each task checks one scenario against hand-computed values.
module tb_if_fetch;
  logic        clock = 1'b0;
  logic        reset;
  logic [5:0]  stop_all;
  logic        branch_flag;
  logic [31:0] branch_target;
  logic [31:0] pc_o;
  logic [31:0] instr_o;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  if_fetch_if rom ();
  assign rom.rom_data = rom.rom_address ^ 32'h0000_1000;

  if_fetch dut (
    .clock                   (clock),
    .reset                   (reset),
    .stop_all_i              (stop_all),
    .branch_flag_i           (branch_flag),
    .branch_target_address_i (branch_target),
    .rom                     (rom),
    .if_program_counter_o    (pc_o),
    .if_instruction_o        (instr_o)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; rom.rom_ready = 1'b0; stop_all = 6'b000000;
    branch_flag = 1'b0; branch_target = 32'h0;
    step(); step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1; rom.rom_ready = 1'b0; stop_all = 6'b000000;
    branch_flag = 1'b0; branch_target = 32'h0;
    step(); step();
    n_cmp++;
    if ({rom.rom_request, rom.rom_address, pc_o, instr_o} !== {1'b0, 96'h0}) begin
      n_bad++;
      $display("FAIL reset_vals: got req=%b addr=%h pc=%h instr=%h, want all zero",
               rom.rom_request, rom.rom_address, pc_o, instr_o);
    end
    reset = 1'b0;
    n_cmp++;
    if (rom.rom_request !== 1'b0) begin
      n_bad++;
      $display("FAIL first_cycle_req: got %b want 0", rom.rom_request);
    end
    step();
    n_cmp++;
    if ({rom.rom_request, rom.rom_address} !== {1'b1, 32'h0}) begin
      n_bad++;
      $display("FAIL second_cycle_req: got req=%b addr=%h want req=1 addr=0",
               rom.rom_request, rom.rom_address);
    end
  endtask

  task automatic test_zero_wait();
    logic [31:0] e_pc;
    do_reset();
    rom.rom_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      e_pc = 32'(i) << 2;
      n_cmp++;
      if ({pc_o, instr_o} !== {e_pc, e_pc ^ 32'h0000_1000}) begin
        n_bad++;
        $display("FAIL zw_out[%0d]: got pc=%h instr=%h want pc=%h instr=%h",
                 i, pc_o, instr_o, e_pc, e_pc ^ 32'h0000_1000);
      end
      n_cmp++;
      if (rom.rom_address !== e_pc + 32'd4) begin
        n_bad++;
        $display("FAIL zw_addr[%0d]: got %h want %h", i, rom.rom_address, e_pc + 32'd4);
      end
    end
  endtask

  task automatic test_wait_states();
    logic [31:0] e_pc;
    do_reset();
    for (int k = 0; k < 2; k++) begin
      e_pc = 32'(k) << 2;
      rom.rom_ready = 1'b0;
      for (int w = 0; w < 2; w++) begin
        step();
        n_cmp++;
        if ({rom.rom_request, rom.rom_address, pc_o, instr_o} !== {1'b1, e_pc, 64'h0}) begin
          n_bad++;
          $display("FAIL ws_bubble[%0d.%0d]: got req=%b addr=%h pc=%h instr=%h want req=1 addr=%h bubble",
                   k, w, rom.rom_request, rom.rom_address, pc_o, instr_o, e_pc);
        end
      end
      rom.rom_ready = 1'b1;
      step();
      n_cmp++;
      if ({pc_o, instr_o} !== {e_pc, e_pc ^ 32'h0000_1000}) begin
        n_bad++;
        $display("FAIL ws_out[%0d]: got pc=%h instr=%h want pc=%h instr=%h",
                 k, pc_o, instr_o, e_pc, e_pc ^ 32'h0000_1000);
      end
    end
    rom.rom_ready = 1'b0;
  endtask

  task automatic test_branch();
    do_reset();
    rom.rom_ready = 1'b1;
    step(); step();
    n_cmp++;
    if (rom.rom_address !== 32'h8) begin
      n_bad++;
      $display("FAIL br_pre_addr: got %h want 00000008", rom.rom_address);
    end
    branch_flag = 1'b1; branch_target = 32'h100;
    step();
    branch_flag = 1'b0;
    n_cmp++;
    if ({pc_o, instr_o, rom.rom_address} !== {32'h8, 32'h1008, 32'h100}) begin
      n_bad++;
      $display("FAIL br_delay_slot: got pc=%h instr=%h addr=%h want 8/1008/100",
               pc_o, instr_o, rom.rom_address);
    end
    step();
    n_cmp++;
    if ({pc_o, instr_o, rom.rom_address} !== {32'h100, 32'h1100, 32'h104}) begin
      n_bad++;
      $display("FAIL br_target: got pc=%h instr=%h addr=%h want 100/1100/104",
               pc_o, instr_o, rom.rom_address);
    end
    step();
    n_cmp++;
    if ({pc_o, instr_o} !== {32'h104, 32'h1104}) begin
      n_bad++;
      $display("FAIL br_next: got pc=%h instr=%h want 104/1104", pc_o, instr_o);
    end
    // Two pulses while waiting: the later target wins after the delay slot.
    rom.rom_ready = 1'b0; branch_flag = 1'b1; branch_target = 32'h200;
    step();
    branch_target = 32'h300;
    step();
    branch_flag = 1'b0; rom.rom_ready = 1'b1;
    step();
    n_cmp++;
    if ({pc_o, instr_o, rom.rom_address} !== {32'h108, 32'h1108, 32'h300}) begin
      n_bad++;
      $display("FAIL br_pending: got pc=%h instr=%h addr=%h want 108/1108/300",
               pc_o, instr_o, rom.rom_address);
    end
    rom.rom_ready = 1'b0; stop_all = 6'b000001;
    branch_flag = 1'b1; branch_target = 32'h400;
    step();
    n_cmp++;
    if ({pc_o, instr_o} !== 64'h0) begin
      n_bad++;
      $display("FAIL br_stop0_bubble: got pc=%h instr=%h want bubble", pc_o, instr_o);
    end
    stop_all = 6'b000000; branch_flag = 1'b0; rom.rom_ready = 1'b1;
    step();
    n_cmp++;
    if ({pc_o, instr_o, rom.rom_address} !== {32'h300, 32'h1300, 32'h304}) begin
      n_bad++;
      $display("FAIL br_ignored_under_stop: got pc=%h instr=%h addr=%h want 300/1300/304",
               pc_o, instr_o, rom.rom_address);
    end
  endtask

  task automatic test_stall();
    logic e_req;
`ifdef IF_HOLD_BUFFER_EN
    e_req = 1'b0;
`else
    e_req = 1'b1;
`endif
    do_reset();
    rom.rom_ready = 1'b1;
    step(); step(); step();
    n_cmp++;
    if (rom.rom_address !== 32'hC) begin
      n_bad++;
      $display("FAIL st_pre_addr: got %h want 0000000c", rom.rom_address);
    end
    stop_all = 6'b000011;
    for (int k = 0; k < 3; k++) begin
      step();
      n_cmp++;
      if ({pc_o, instr_o, rom.rom_request, rom.rom_address} !== {32'h8, 32'h1008, e_req, 32'hC}) begin
        n_bad++;
        $display("FAIL st_hold[%0d]: got pc=%h instr=%h req=%b addr=%h want 8/1008/%b/c",
                 k, pc_o, instr_o, rom.rom_request, rom.rom_address, e_req);
      end
    end
    stop_all = 6'b000000;
`ifdef IF_HOLD_BUFFER_EN
    rom.rom_ready = 1'b0;
`endif
    n_cmp++;
    if (rom.rom_request !== e_req) begin
      n_bad++;
      $display("FAIL st_release_req: got %b want %b", rom.rom_request, e_req);
    end
    step();
    n_cmp++;
    if ({pc_o, instr_o, rom.rom_address} !== {32'hC, 32'h100C, 32'h10}) begin
      n_bad++;
      $display("FAIL st_release_out: got pc=%h instr=%h addr=%h want c/100c/10",
               pc_o, instr_o, rom.rom_address);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    rom.rom_ready = 1'b1;
    step(); step(); step(); step();
    rom.rom_ready = 1'b0; reset = 1'b1;
    step();
    n_cmp++;
    if ({rom.rom_request, rom.rom_address, pc_o, instr_o} !== {1'b0, 96'h0}) begin
      n_bad++;
      $display("FAIL rm_reset: got req=%b addr=%h pc=%h instr=%h want all zero",
               rom.rom_request, rom.rom_address, pc_o, instr_o);
    end
    reset = 1'b0; rom.rom_ready = 1'b1;
    step();
    n_cmp++;
    if ({rom.rom_request, rom.rom_address, pc_o, instr_o} !== {1'b1, 96'h0}) begin
      n_bad++;
      $display("FAIL rm_stray_ready: got req=%b addr=%h pc=%h instr=%h want req=1 rest zero",
               rom.rom_request, rom.rom_address, pc_o, instr_o);
    end
    step();
    n_cmp++;
    if ({pc_o, instr_o, rom.rom_address} !== {32'h0, 32'h1000, 32'h4}) begin
      n_bad++;
      $display("FAIL rm_restart: got pc=%h instr=%h addr=%h want 0/1000/4",
               pc_o, instr_o, rom.rom_address);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_branch();
    test_stall();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
